// File: rtl/acc_drain_ctrl.sv
// acc_drain_ctrl: read-side master that drains a contiguous accumulator window
// through a fixed-latency read port into a small skid FIFO and streams the words
// out on a valid/ready bus with a LAST marker. Reads are only issued while the
// FIFO has room for every read already in flight, so backpressure never drops data.
// Optional feature macro: CLEAR_ON_READ_EN (zero each word one cycle after reading it).
module acc_drain_ctrl #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 64,
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_rdata,
  output logic                  wr_en,
  output logic                  wr_we,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_wdata,
  output logic                  acc_mode,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + RD_LATENCY + 1) + 1;
  localparam logic [ADDR_WIDTH:0] LEN_ONE = (ADDR_WIDTH + 1)'(1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_t;

  state_t state, next_state;

  logic [ADDR_WIDTH-1:0] base_r;
  logic [ADDR_WIDTH:0]   len_r;
  logic [ADDR_WIDTH:0]   idx;
  logic [ADDR_WIDTH:0]   out_idx;
  logic                  zero_done;
  logic [RD_LATENCY-1:0] tag;
  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]         wptr;
  logic [PW-1:0]         rptr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         inflight;
  logic                  launch;
  logic                  push;
  logic                  pop;
  logic                  has_credit;
  logic                  finish;
  logic                  clear_idle;

  assign busy       = (state != IDLE) || zero_done;
  assign launch     = (state == IDLE) && !zero_done && start;
  assign push       = tag[RD_LATENCY-1];
  assign m_valid    = (count != '0);
  assign pop        = m_valid && m_ready;
  assign m_data     = m_valid ? fifo_mem[rptr] : '0;
  assign m_last     = m_valid && (out_idx == (len_r - LEN_ONE));
  assign rd_addr    = base_r + idx[ADDR_WIDTH-1:0];
  assign has_credit = ((count + inflight) < CW'(FIFO_DEPTH));
  assign done       = finish || zero_done;

  // Count reads whose data has not yet come back from the accumulator.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + CW'(tag[i]);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic, read issue and end-of-drain detection.
  always_comb begin
    next_state = state;
    rd_en      = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (launch && (len != '0)) begin
          next_state = RUN;
        end
      end
      RUN: begin
        if ((idx < len_r) && has_credit) begin
          rd_en = 1'b1;
          if (idx == (len_r - LEN_ONE)) begin
            next_state = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (pop && m_last && (count == CW'(1)) && (inflight == '0) && clear_idle) begin
          finish     = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Latch the window on launch and track read/output progress through it.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      base_r    <= '0;
      len_r     <= '0;
      idx       <= '0;
      out_idx   <= '0;
      zero_done <= 1'b0;
    end else begin
      zero_done <= launch && (len == '0);
      if (launch) begin
        base_r  <= base_addr;
        len_r   <= len;
        idx     <= '0;
        out_idx <= '0;
      end else begin
        if (rd_en) begin
          idx <= idx + LEN_ONE;
        end
        if (pop) begin
          out_idx <= out_idx + LEN_ONE;
        end
      end
    end
  end

  // Shift a valid tag along with each read so the returning word is captured on time.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      tag <= '0;
    end else begin
      tag[0] <= rd_en;
      for (int i = 1; i < RD_LATENCY; i++) begin
        tag[i] <= tag[i-1];
      end
    end
  end

  // Skid FIFO storage; entries are only meaningful while counted as occupied.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wptr] <= rd_rdata;
    end
  end

  // Skid FIFO pointers and occupancy; a push and pop together leave the count unchanged.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wptr <= (wptr == PW'(FIFO_DEPTH - 1)) ? '0 : wptr + PW'(1);
      end
      if (pop) begin
        rptr <= (rptr == PW'(FIFO_DEPTH - 1)) ? '0 : rptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef CLEAR_ON_READ_EN
  logic                  clr_valid;
  logic [ADDR_WIDTH-1:0] clr_addr;

  // Zero each word one cycle after its read so the clear never collides with that read.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      clr_valid <= 1'b0;
      clr_addr  <= '0;
    end else begin
      clr_valid <= rd_en;
      clr_addr  <= rd_en ? rd_addr : '0;
    end
  end

  assign wr_en      = clr_valid;
  assign wr_we      = clr_valid;
  assign wr_addr    = clr_addr;
  assign wr_wdata   = '0;
  assign acc_mode   = 1'b0;
  assign clear_idle = !clr_valid;
`else
  assign wr_en      = 1'b0;
  assign wr_we      = 1'b0;
  assign wr_addr    = '0;
  assign wr_wdata   = '0;
  assign acc_mode   = 1'b0;
  assign clear_idle = 1'b1;
`endif

endmodule

// File: tb/tb_acc_drain_ctrl.sv
// tb_acc_drain_ctrl: randomized scoreboard bench for acc_drain_ctrl with a
// behavioural accumulator memory (fixed read latency) and a reference memory image.
module tb_acc_drain_ctrl;

  localparam int AW = 9;
  localparam int DW = 64;
  localparam int L  = 2;
  localparam int FD = 4;
  localparam int NW = 1 << AW;

  logic          clk;
  logic          rstn;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic          busy;
  logic          done;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_rdata;
  logic          wr_en;
  logic          wr_we;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_wdata;
  logic          acc_mode;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;

  // Backdoor preload port into the memory model.
  logic          tb_we;
  logic [AW-1:0] tb_waddr;
  logic [DW-1:0] tb_wdata;

  logic [DW-1:0] mem      [NW];
  logic [DW-1:0] ref_mem  [NW];
  logic [DW-1:0] pipe     [L];

  logic [DW-1:0] exp_data [$];
  bit            exp_last [$];
  logic [AW-1:0] exp_addr [$];
  logic [AW-1:0] exp_clr  [$];

  int checks;
  int errors;
  int cyc;
  int done_seen;
  int done_cyc;
  int pop_total;
  int outstanding;
  int ready_mode;
  int rpat;

  acc_drain_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RD_LATENCY (L),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_rdata  (rd_rdata),
    .wr_en     (wr_en),
    .wr_we     (wr_we),
    .wr_addr   (wr_addr),
    .wr_wdata  (wr_wdata),
    .acc_mode  (acc_mode),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used for latency checks.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Accumulator model: synchronous writes, reads returned L cycles after rd_en.
  assign rd_rdata = pipe[L-1];
  always @(posedge clk) begin
    if (tb_we) mem[tb_waddr] <= tb_wdata;
    if (wr_en && wr_we) mem[wr_addr] <= wr_wdata;
    pipe[0] <= rd_en ? mem[rd_addr] : 64'hBAD0_BAD0_BAD0_BAD0;
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end

  // Downstream ready: always on, random, or a 1,0,0 repeating pattern.
  initial begin
    m_ready = 1'b1;
    rpat    = 0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = 1'($urandom_range(0, 1));
        default: begin
          m_ready = (rpat == 0);
          rpat    = (rpat + 1) % 3;
        end
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: scoreboards reads, output words, clears and done pulses.
  always @(negedge clk) begin
    if (!rstn) begin
      outstanding = 0;
    end else begin
      if (rd_en) begin
        checkOutput("rd_en_allowed", 64'(rd_en), 64'(exp_addr.size() != 0));
        if (exp_addr.size() != 0) checkOutput("rd_addr", 64'(rd_addr), 64'(exp_addr.pop_front()));
        outstanding++;
        checkOutput("credit_bound", 64'(outstanding > FD), 64'd0);
      end
      if (m_valid && m_ready) begin
        checkOutput("word_expected", 64'(m_valid), 64'(exp_data.size() != 0));
        if (exp_data.size() != 0) begin
          checkOutput("m_data", m_data, exp_data.pop_front());
          checkOutput("m_last", 64'(m_last), 64'(exp_last.pop_front()));
        end
        outstanding--;
        pop_total++;
      end
      if (wr_en) begin
        checkOutput("wr_en_allowed", 64'(wr_en), 64'(exp_clr.size() != 0));
        if (exp_clr.size() != 0) checkOutput("wr_addr", 64'(wr_addr), 64'(exp_clr.pop_front()));
        checkOutput("wr_we", 64'(wr_we), 64'd1);
        checkOutput("wr_wdata", wr_wdata, 64'd0);
      end
      if (done) begin
        done_seen++;
        done_cyc = cyc;
      end
    end
  end

  task automatic preloadWord(input int a, input logic [DW-1:0] d);
    @(posedge clk);
    #1;
    tb_we    = 1'b1;
    tb_waddr = AW'(a);
    tb_wdata = d;
    ref_mem[a] = d;
  endtask

  task automatic preloadDone();
    @(posedge clk);
    #1;
    tb_we = 1'b0;
  endtask

  // Reference model: words in address order from the image, last flag on the final one.
  task automatic pushExpect(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      int a;
      a = (base + i) % NW;
      exp_addr.push_back(AW'(a));
      exp_data.push_back(ref_mem[a]);
      exp_last.push_back(i == n - 1);
`ifdef CLEAR_ON_READ_EN
      exp_clr.push_back(AW'(a));
      ref_mem[a] = '0;
`endif
    end
  endtask

  task automatic resetCheck();
    checkOutput("rst_busy",     64'(busy),     64'd0);
    checkOutput("rst_done",     64'(done),     64'd0);
    checkOutput("rst_rd_en",    64'(rd_en),    64'd0);
    checkOutput("rst_rd_addr",  64'(rd_addr),  64'd0);
    checkOutput("rst_wr_en",    64'(wr_en),    64'd0);
    checkOutput("rst_wr_we",    64'(wr_we),    64'd0);
    checkOutput("rst_wr_addr",  64'(wr_addr),  64'd0);
    checkOutput("rst_wr_wdata", wr_wdata,      64'd0);
    checkOutput("rst_acc_mode", 64'(acc_mode), 64'd0);
    checkOutput("rst_m_valid",  64'(m_valid),  64'd0);
    checkOutput("rst_m_last",   64'(m_last),   64'd0);
    checkOutput("rst_m_data",   m_data,        64'd0);
  endtask

  task automatic clearQueues();
    exp_data.delete();
    exp_last.delete();
    exp_addr.delete();
    exp_clr.delete();
  endtask

  // Run one drain and check completion, latency (when ready is held) and idle state afterwards.
  task automatic applyStimulus(input int base, input int n, input int mode, input bit poke_busy);
    int s;
    int t;
    ready_mode = mode;
    t = 0;
    while (busy && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    pushExpect(base, n);
    done_seen = 0;
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = AW'(base);
    len       = (AW + 1)'(n);
    s         = cyc;
    @(posedge clk);
    #1;
    start     = 1'b0;
    base_addr = AW'($urandom);
    len       = (AW + 1)'($urandom_range(0, NW));
    if (poke_busy) begin
      @(posedge clk);
      #1;
      start     = 1'b1;
      base_addr = AW'(9'h100);
      len       = (AW + 1)'(7);
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    t = 0;
    while (done_seen == 0 && t < 4 * n + 40) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("done_pulses", 64'(done_seen), 64'd1);
    if (mode == 0) checkOutput("done_latency", 64'(done_cyc - s), 64'((n == 0) ? 1 : 1 + L + n));
    checkOutput("words_left", 64'(exp_data.size()), 64'd0);
    checkOutput("reads_left", 64'(exp_addr.size()), 64'd0);
    checkOutput("clears_left", 64'(exp_clr.size()), 64'd0);
    checkOutput("busy_after", 64'(busy), 64'd0);
    checkOutput("m_valid_after", 64'(m_valid), 64'd0);
    checkOutput("acc_mode", 64'(acc_mode), 64'd0);
    clearQueues();
  endtask

  // Global time limit so the bench always terminates.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence.
  initial begin
    int s;
    int t;
    int p0;
    checks = 0; errors = 0; done_seen = 0; done_cyc = 0; pop_total = 0; outstanding = 0;
    ready_mode = 0;
    rstn = 1'b0; start = 1'b0; base_addr = '0; len = '0;
    tb_we = 1'b0; tb_waddr = '0; tb_wdata = '0;

    // Preload the whole accumulator while reset is held.
    for (int a = 0; a < NW; a++) begin
      if (a >= 16 && a < 20) preloadWord(a, 64'((a - 15) * 100));
      else preloadWord(a, {$urandom, $urandom});
    end
    preloadDone();
    @(negedge clk);
    resetCheck();
    @(posedge clk);
    #1;
    rstn = 1'b1;

    $display("[TB] T1 basic drain, ready held");
    applyStimulus(16, 4, 0, 1'b0);

    $display("[TB] T2 backpressure pattern, start while busy");
    for (int a = 16; a < 20; a++) preloadWord(a, 64'((a - 15) * 100));
    preloadDone();
    applyStimulus(16, 4, 2, 1'b1);

    $display("[TB] T3 address wrap");
    applyStimulus(9'h1FE, 4, 1, 1'b0);

    $display("[TB] T4 zero length");
    ready_mode = 0;
    done_seen  = 0;
    @(posedge clk);
    #1;
    start = 1'b1; base_addr = AW'(32); len = '0;
    s = cyc;
    @(posedge clk);
    #1;
    len = (AW + 1)'(4);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    checkOutput("len0_done_pulses", 64'(done_seen), 64'd1);
    checkOutput("len0_done_latency", 64'(done_cyc - s), 64'd1);
    checkOutput("len0_busy_after", 64'(busy), 64'd0);

    $display("[TB] T5 reset mid-drain");
    for (int a = 16; a < 24; a++) preloadWord(a, 64'((a - 15) * 100));
    preloadDone();
    ready_mode = 0;
    pushExpect(16, 8);
    p0 = pop_total;
    @(posedge clk);
    #1;
    start = 1'b1; base_addr = AW'(16); len = (AW + 1)'(8);
    @(posedge clk);
    #1;
    start = 1'b0;
    t = 0;
    while (pop_total < p0 + 2 && t < 50) begin
      @(posedge clk);
      t++;
    end
    checkOutput("t5_two_words", 64'(pop_total - p0 >= 2), 64'd1);
    #1;
    rstn = 1'b0;
    clearQueues();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    resetCheck();
    applyStimulus(64, 4, 0, 1'b0);
    for (int a = 16; a < 24; a++) preloadWord(a, 64'((a - 15) * 100));
    preloadDone();

    $display("[TB] T6 drain the same window twice");
    applyStimulus(16, 4, 0, 1'b0);
    applyStimulus(16, 4, 1, 1'b0);

    $display("[TB] random drains");
    for (int k = 0; k < 14; k++) begin
      applyStimulus($urandom_range(0, NW - 1), ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 24),
                    $urandom_range(0, 2), 1'b0);
    end

    $display("[TB] full-window drain");
    applyStimulus($urandom_range(0, NW - 1), NW, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
